axi_burst_master: RTL
=====================

# axi_burst_master

AXI-style burst initiator that turns single-command requests into address/data/response traffic toward the memory slave. Takes a command (direction, word address, beat count), streams write beats from a valid/ready source or read beats to a valid/ready sink, and reports completion and error. It sits between pipeline blocks (frame buffers, DMA control) and the AXI memory slave. Addressing is in words: one address step is one DATA_WIDTH beat, with INCR bursts only.

## Interface
- ADDR_WIDTH, 32, address width in words
- DATA_WIDTH, 32, beat width
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with AXI_MASTER_TIMEOUT_EN
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start word address
- cmd_len  in  8  beats minus one (AXI len encoding)
- wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH/1/1  write beat source
- rd_data / rd_valid / rd_ready / rd_last  out / out / in / out  DATA_WIDTH/1/1/1  read beat sink
- awaddr, awlen, awvalid / awready  out, out, out / in  ADDR_WIDTH, 8, 1  write address
- wdata, wvalid, wlast / wready  out / in  DATA_WIDTH, 1, 1  write data
- bresp, bvalid / bready  in / out  2, 1  write response
- araddr, arlen, arvalid / arready  out / in  ADDR_WIDTH, 8, 1  read address
- rdata, rvalid, rlast / rready  in / out  DATA_WIDTH, 1, 1  read data
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  error status, qualified by done

## Operation
- States: IDLE, AW, W, B, AR, R.
- IDLE: cmd_ready=1. When cmd_valid&&cmd_ready, register addr, len, and write. Go to AW if write=1, else AR. Clear beat_cnt.
- AW: awvalid=1, with awaddr/awlen from the registered command. On awvalid&&awready, go to W. awvalid must hold stable until that handshake.
- W: wvalid=wr_valid, wr_ready=wready, wdata=wr_data, wlast=(beat_cnt==len). Each wvalid&&wready increments beat_cnt. The handshake with wlast goes to B.
- B: bready=1. On bvalid, go to IDLE and pulse done. err=bresp[1], so OKAY(00) and EXOKAY(01) count as success.
- AR: arvalid=1 until arready. Then go to R.
- R: rready=rd_ready, rd_valid=rvalid, rd_data=rdata, rd_last=rlast. Each rvalid&&rready increments beat_cnt. The handshake with rlast goes to IDLE and pulses done. err=1 if rlast arrives with beat_cnt!=len.
- Outside their owning state, all AXI valids/readies and the stream readies/valids are 0.
- beat_cnt is 8 bits with no wrap: len=255 gives 256 beats. len=0 gives a single beat with wlast on the first beat.
- Reset mid-burst: IDLE at the next edge. Outstanding slave transactions are abandoned, and the bench must also reset the slave.

## Timing
- Reset values: cmd_ready=1. awvalid, wvalid, wlast, bready, arvalid, rready, rd_valid, rd_last, done, err, busy are 0. awaddr, araddr, awlen, arlen are 0.
- Command accept → awvalid/arvalid high on the next cycle (1-cycle latency).
- W/R stream signals are combinational pass-through; there is no added latency per beat, and back-to-back beats run every cycle.
- done/err are registered and asserted the cycle after the final B or R handshake. cmd_ready returns the same cycle.
- Minimum write of 1 beat: accept, AW, W, B gives done 4 cycles after accept with zero-wait slave. Minimum read of 1 beat: 3 cycles.

## Configuration
- AXI_MASTER_TIMEOUT_EN defined: a counter restarts on every state change and every beat handshake. When it reaches TIMEOUT_CYCLES in AW/W/B/AR/R, the block forces IDLE, pulses done with err=1, and drops all valids/readies.
- Undefined: no counter. The block waits indefinitely.

## Structure
- axi_master_pkg: state enum, RESP_OKAY/EXOKAY/SLVERR/DECERR constants, len width constant.
- One sub-module, axi_master_watchdog: counter plus expiry flag, instantiated only under the macro.

## Test plan
- Write cmd addr=0x10, len=3, data A0..A3, slave zero-wait, bresp=01 → 4 W beats, wlast on A3 only, done=1, err=0, readback 0x10..0x13 = A0..A3.
- Read cmd addr=0x05, len=0 → single beat with rd_last=1, done one cycle after it, err=0.
- Read len=7 with rd_ready toggling every other cycle → 8 beats delivered in order, none lost or duplicated, rready tracks rd_ready.
- Write with bresp=10 → done with err=1. Read with rlast on beat 2 of len=3 → err=1.
- Macro on, TIMEOUT_CYCLES=16, bvalid never asserted → done+err 16 cycles after entering B, then IDLE.
- rst_n low during beat 2 of a len=7 write → next cycle all valids 0, busy=0, cmd_ready=1.

Source files
------------

// File: rtl/axi_master_pkg.sv
// axi_master_pkg: shared types and constants for axi_burst_master.
//   state_e      - burst FSM states
//   RESP_*       - AXI response encodings
//   LenWidth     - width of AXI len / beat counter
package axi_master_pkg;

  localparam int unsigned LenWidth = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR
  } state_e;

endpackage

// File: rtl/axi_master_watchdog.sv
// axi_master_watchdog: stall watchdog for axi_burst_master.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   active      - block is in a non-idle state; counter held at zero otherwise
//   restart     - progress seen this cycle (state change or beat); counter reloads
//   expired     - TIMEOUT_CYCLES cycles without progress have elapsed
module axi_master_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || restart || !active) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q counts completed idle cycles; the last one is the expiry cycle.
  assign expired = active && (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axi_burst_master.sv
// axi_burst_master: single-command AXI-style INCR burst initiator (word addressing).
// Optional feature macro: AXI_MASTER_TIMEOUT_EN (stall watchdog, TIMEOUT_CYCLES limit).
// Ports:
//   clk, rst_n                       - clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/len   - burst command (len = beats - 1)
//   wr_data/valid/ready              - write beat source
//   rd_data/valid/ready/last         - read beat sink
//   aw*, w*, b*, ar*, r*             - AXI master channels
//   busy                             - not idle
//   done, err                        - one-cycle completion pulse, error qualified by done
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LenWidth-1:0]   cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [LenWidth-1:0]   awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  output logic                  wlast,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [LenWidth-1:0]   arlen,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  rready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LenWidth-1:0]   len_q;
  logic [LenWidth-1:0]   beat_cnt_q, beat_cnt_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  w_hs, r_hs, last_beat, timeout;

  assign w_hs      = (state_q == StW) && wr_valid && wready;
  assign r_hs      = (state_q == StR) && rvalid && rd_ready;
  assign last_beat = (beat_cnt_q == len_q);

`ifdef AXI_MASTER_TIMEOUT_EN
  logic wd_restart;
  assign wd_restart = (state_d != state_q) || w_hs || r_hs;

  axi_master_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (state_q != StIdle),
    .restart(wd_restart),
    .expired(timeout)
  );
`else
  // Constant low; the reference keeps TIMEOUT_CYCLES in use when the watchdog is absent.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES == 0);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, beat counter and completion registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && cmd_valid) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
      end
      beat_cnt_q <= beat_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d    = cmd_write ? StAw : StAr;
          beat_cnt_d = '0;
        end
      end
      StAw: if (awready) state_d = StW;
      StW: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) state_d = StB;
        end
      end
      StB: begin
        if (bvalid) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = (bresp == RESP_SLVERR) || (bresp == RESP_DECERR);
        end
      end
      StAr: if (arready) state_d = StR;
      StR: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (rlast) begin
            state_d = StIdle;
            done_d  = 1'b1;
            // Slave ended the burst early or late.
            err_d   = !last_beat;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (timeout) begin
      state_d = StIdle;
      done_d  = 1'b1;
      err_d   = 1'b1;
    end
  end

  // Outputs
  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wr_ready  = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    unique case (state_q)
      StIdle: cmd_ready = 1'b1;
      StAw:   awvalid   = 1'b1;
      StW: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = last_beat;
      end
      StB:    bready    = 1'b1;
      StAr:   arvalid   = 1'b1;
      StR: begin
        rready   = rd_ready;
        rd_valid = rvalid;
        rd_last  = rlast;
      end
      default: ;
    endcase
  end

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = len_q;
  assign arlen   = len_q;
  assign wdata   = wr_data;
  assign rd_data = rdata;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;

endmodule
